gcd_engine: RTL

- Self-contained, parametrised GCD unit: integrated controller plus datapath, replacing the externally sequenced x_sel/y_sel/x_load/y_load scheme.
- Operands arrive through a valid/ready input handshake. The result leaves through a valid/ready output handshake.
- Supports subtractive Euclid or binary (Stein) iteration, selectable by parameter. Reports an iteration count for performance monitoring.

---
 rtl/gcd_pkg.sv | 22 ++
 rtl/gcd_step.sv | 49 ++++
 rtl/gcd_engine.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared constants for the GCD engine: FSM state encoding and algorithm selectors.
package gcd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ALGO_SUB = 0;
  localparam int ALGO_BIN = 1;

  // Saturating increment, used by the iteration counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    logic [63:0] res;
    if (val == max_val) begin
      res = val;
    end else begin
      res = val + 64'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// Combinational single-iteration step of the GCD loop (subtractive Euclid or binary Stein).
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ALGO  = ALGO_SUB
) (
  input  logic [WIDTH-1:0]        x,
  input  logic [WIDTH-1:0]        y,
  input  logic [$clog2(WIDTH):0]  k,
  output logic [WIDTH-1:0]        x_nxt,
  output logic [WIDTH-1:0]        y_nxt,
  output logic [$clog2(WIDTH):0]  k_nxt,
  output logic                    done,
  output logic                    step
);

  localparam bit BIN_MODE = (ALGO == ALGO_BIN);

  // Priority-ordered step selection; subtraction is guarded by the magnitude compare.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    k_nxt = k;
    done  = 1'b0;
    step  = 1'b0;
    if (x == y) begin
      done = 1'b1;
    end else if (BIN_MODE && !x[0] && !y[0]) begin
      x_nxt = {1'b0, x[WIDTH-1:1]};
      y_nxt = {1'b0, y[WIDTH-1:1]};
      k_nxt = k + 1'b1;
      step  = 1'b1;
    end else if (BIN_MODE && !x[0]) begin
      x_nxt = {1'b0, x[WIDTH-1:1]};
      step  = 1'b1;
    end else if (BIN_MODE && !y[0]) begin
      y_nxt = {1'b0, y[WIDTH-1:1]};
      step  = 1'b1;
    end else if (x > y) begin
      x_nxt = x - y;
      step  = 1'b1;
    end else begin
      y_nxt = y - x;
      step  = 1'b1;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Self-sequenced GCD unit: valid/ready operand intake, iterative datapath, valid/ready result.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ALGO  = ALGO_SUB,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy
);

  localparam int KW = $clog2(WIDTH) + 1;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [KW-1:0]    k_r;
  logic [WIDTH-1:0] gcd_r;
  logic [CNT_W-1:0] iter_count_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [WIDTH-1:0] x_step_s;
  logic [WIDTH-1:0] y_step_s;
  logic [KW-1:0]    k_step_s;
  logic             done_s;
  logic             step_s;
  logic             accept_s;
  logic             zero_op_s;
  logic [CNT_W-1:0] iter_inc_s;

  gcd_step #(
    .WIDTH (WIDTH),
    .ALGO  (ALGO)
  ) u_step (
    .x     (x_r),
    .y     (y_r),
    .k     (k_r),
    .x_nxt (x_step_s),
    .y_nxt (y_step_s),
    .k_nxt (k_step_s),
    .done  (done_s),
    .step  (step_s)
  );

  // Handshake qualifiers and saturating counter increment.
  always_comb begin
    accept_s   = in_valid && (state_r == ST_IDLE);
    zero_op_s  = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
    if (iter_count_r == {CNT_W{1'b1}}) begin
      iter_inc_s = iter_count_r;
    end else begin
      iter_inc_s = iter_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic; a result handshake returns to IDLE without a same-cycle accept.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (zero_op_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (done_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered status flags decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s == ST_CALC);
    end
  end

  // Datapath: operand capture, iteration, and result/count hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r          <= {WIDTH{1'b0}};
      y_r          <= {WIDTH{1'b0}};
      k_r          <= {KW{1'b0}};
      gcd_r        <= {WIDTH{1'b0}};
      iter_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            x_r          <= a;
            y_r          <= b;
            k_r          <= {KW{1'b0}};
            iter_count_r <= {CNT_W{1'b0}};
            if (zero_op_s) begin
              gcd_r <= a | b;
            end else begin
              gcd_r <= gcd_r;
            end
          end else begin
            x_r <= x_r;
          end
        end
        ST_CALC: begin
          if (done_s) begin
            gcd_r <= x_r << k_r;
          end else begin
            x_r <= x_step_s;
            y_r <= y_step_s;
            k_r <= k_step_s;
            if (step_s) begin
              iter_count_r <= iter_inc_s;
            end else begin
              iter_count_r <= iter_count_r;
            end
          end
        end
        ST_DONE: begin
          gcd_r <= gcd_r;
        end
        default: begin
          x_r <= x_r;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign gcd        = gcd_r;
  assign iter_count = iter_count_r;

endmodule
